// File: rtl/gpr_wb_queue.sv
// rtl/gpr_wb_queue.sv - in-order GPR writeback queue with youngest-match read bypass
module gpr_wb_queue #(
    parameter int DEPTH   = 4,
    parameter int ID_BITS = 5,
    parameter int XLEN    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ID_BITS-1:0]         in_id,
    input  logic [XLEN-1:0]            in_val,
    input  logic                       wb_stall,
    output logic                       gpr_we,
    output logic [ID_BITS-1:0]         gpr_write_id,
    output logic [XLEN-1:0]            gpr_write_val,
    input  logic [ID_BITS-1:0]         rd1_id,
    input  logic [ID_BITS-1:0]         rd2_id,
    output logic                       rd1_hit,
    output logic                       rd2_hit,
    output logic [XLEN-1:0]            rd1_val,
    output logic [XLEN-1:0]            rd2_val,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [ID_BITS-1:0] ids  [DEPTH];
    logic [XLEN-1:0]    vals [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic               push;
    logic               pop;
    logic [PTR_W-1:0]   idx;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign in_ready = !full;
    // Writes to r0 complete the handshake but are discarded.
    assign push     = in_valid && in_ready && (in_id != '0);
    assign gpr_we   = !empty && !wb_stall;
    assign pop      = gpr_we;

    assign gpr_write_id  = empty ? '0 : ids[head];
    assign gpr_write_val = empty ? '0 : vals[head];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ids[tail]  <= in_id;
            vals[tail] <= in_val;
        end
    end

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        rd1_hit = 1'b0;
        rd1_val = '0;
        rd2_hit = 1'b0;
        rd2_val = '0;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (CNT_W'(i) < count) begin
                if (rd1_id != '0 && ids[idx] == rd1_id) begin
                    rd1_hit = 1'b1;
                    rd1_val = vals[idx];
                end
                if (rd2_id != '0 && ids[idx] == rd2_id) begin
                    rd2_hit = 1'b1;
                    rd2_val = vals[idx];
                end
            end
        end
    end
endmodule

// File: tb/tb_gpr_wb_queue.sv
// tb/tb_gpr_wb_queue.sv - directed vector bench for gpr_wb_queue
module tb_gpr_wb_queue;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, wb_stall, gpr_we;
    logic [4:0]    in_id, gpr_write_id, rd1_id, rd2_id;
    logic [31:0]   in_val, gpr_write_val, rd1_val, rd2_val;
    logic          rd1_hit, rd2_hit, empty, full;
    logic [CW-1:0] count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gpr_wb_queue #(.DEPTH(DEPTH), .ID_BITS(5), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id), .in_val(in_val),
        .wb_stall(wb_stall), .gpr_we(gpr_we),
        .gpr_write_id(gpr_write_id), .gpr_write_val(gpr_write_val),
        .rd1_id(rd1_id), .rd2_id(rd2_id),
        .rd1_hit(rd1_hit), .rd2_hit(rd2_hit), .rd1_val(rd1_val), .rd2_val(rd2_val),
        .count(count), .empty(empty), .full(full)
    );

    typedef struct {
        logic        v;
        logic [4:0]  id;
        logic [31:0] val;
        logic        st;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        e_rdy;
        logic        e_we;
        logic [4:0]  e_wid;
        logic [31:0] e_wval;
        logic [2:0]  e_cnt;
        logic        e_h1;
        logic [31:0] e_v1;
        logic        e_h2;
        logic [31:0] e_v2;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  p, w;
        logic took, any_we;

        vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0};
        vecs[1] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 5'd0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 3'd1, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 5'd0, 32'h1234,     1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0};
        vecs[3] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0};
        vecs[4] = '{1'b1, 5'd3, 32'h1,        1'b1, 5'd3, 5'd4, 1'b1, 1'b0, 5'd0, 32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0};
        vecs[5] = '{1'b1, 5'd3, 32'h2,        1'b1, 5'd3, 5'd4, 1'b1, 1'b0, 5'd3, 32'h1,        3'd1, 1'b1, 32'h1,        1'b0, 32'h0};
        vecs[6] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 5'd4, 1'b1, 1'b0, 5'd3, 32'h1,        3'd2, 1'b1, 32'h2,        1'b0, 32'h0};
        vecs[7] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 32'h1,        3'd2, 1'b1, 32'h2,        1'b1, 32'h2};
        vecs[8] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 32'h2,        3'd1, 1'b1, 32'h2,        1'b1, 32'h2};
        vecs[9] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd3, 5'd3, 1'b1, 1'b0, 5'd0, 32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0};

        rst = 1'b1; in_valid = 1'b0; in_id = '0; in_val = '0;
        wb_stall = 1'b0; rd1_id = '0; rd2_id = '0;
        tick();
        tick();
        chk("reset.count", count, 0);
        chk("reset.empty", empty, 1);
        chk("reset.full", full, 0);
        chk("reset.we", gpr_we, 0);
        chk("reset.ready", in_ready, 1);
        chk("reset.wid", gpr_write_id, 0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            in_valid = vecs[i].v; in_id = vecs[i].id; in_val = vecs[i].val;
            wb_stall = vecs[i].st; rd1_id = vecs[i].r1; rd2_id = vecs[i].r2;
            #1;
            chk($sformatf("v%0d.ready", i), in_ready, vecs[i].e_rdy);
            chk($sformatf("v%0d.we", i), gpr_we, vecs[i].e_we);
            chk($sformatf("v%0d.wid", i), gpr_write_id, vecs[i].e_wid);
            chk($sformatf("v%0d.wval", i), gpr_write_val, vecs[i].e_wval);
            chk($sformatf("v%0d.count", i), count, vecs[i].e_cnt);
            chk($sformatf("v%0d.hit1", i), rd1_hit, vecs[i].e_h1);
            chk($sformatf("v%0d.val1", i), rd1_val, vecs[i].e_v1);
            chk($sformatf("v%0d.hit2", i), rd2_hit, vecs[i].e_h2);
            chk($sformatf("v%0d.val2", i), rd2_val, vecs[i].e_v2);
            tick();
        end
        chk("v.empty_after", empty, 1);

        // fill while stalled, hold a fifth push, then drain
        in_valid = 1'b1; wb_stall = 1'b1; rd1_id = '0; rd2_id = '0;
        for (int i = 1; i <= 4; i++) begin
            in_id = 5'(i); in_val = 32'h10 + 32'(i);
            tick();
        end
        chk("full.full", full, 1);
        chk("full.ready", in_ready, 0);
        chk("full.count", count, 4);
        in_id = 5'd5; in_val = 32'h15;
        tick();
        chk("full.held_count", count, 4);
        wb_stall = 1'b0;
        #1;
        chk("drain0.we", gpr_we, 1);
        chk("drain0.wid", gpr_write_id, 1);
        chk("drain0.ready", in_ready, 0);
        tick();
        chk("drain1.wid", gpr_write_id, 2);
        chk("drain1.ready", in_ready, 1);
        chk("drain1.count", count, 3);
        tick();
        in_valid = 1'b0;
        chk("drain2.wid", gpr_write_id, 3);
        chk("drain2.count", count, 3);
        tick();
        chk("drain3.wid", gpr_write_id, 4);
        chk("drain3.count", count, 2);
        tick();
        chk("drain4.wid", gpr_write_id, 5);
        chk("drain4.wval", gpr_write_val, 32'h15);
        tick();
        chk("drain5.empty", empty, 1);
        chk("drain5.we", gpr_we, 0);

        // ordering across pointer wrap with alternating stall
        p = 0; w = 0;
        for (int c = 0; c < 100 && w < 10; c++) begin
            in_valid = (p < 10);
            in_id    = 5'(p + 1);
            in_val   = 32'h100 + 32'(p);
            wb_stall = c[0];
            #1;
            if (gpr_we) begin
                chk($sformatf("wrap%0d.id", w), gpr_write_id, 64'(w + 1));
                chk($sformatf("wrap%0d.val", w), gpr_write_val, 64'(32'h100 + w));
                w++;
            end
            took = in_valid && in_ready;
            tick();
            if (took) p++;
        end
        in_valid = 1'b0;
        chk("wrap.writes", 64'(w), 10);
        chk("wrap.pushes", 64'(p), 10);
        #1;
        chk("wrap.empty", empty, 1);

        // asynchronous reset with entries pending
        wb_stall = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_id = 5'(7 + i); in_val = 32'h700 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        chk("rst.pre_count", count, 3);
        wb_stall = 1'b0;
        #1;
        chk("rst.pre_we", gpr_we, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst.count", count, 0);
        chk("rst.we", gpr_we, 0);
        chk("rst.empty", empty, 1);
        chk("rst.wid", gpr_write_id, 0);
        tick();
        rst = 1'b0;
        any_we = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (gpr_we) any_we = 1'b1;
            tick();
        end
        chk("rst.no_writes_after", any_we, 0);
        chk("rst.count_after", count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
